// File: rtl/cache_mem_arbiter.sv
// Two-port cache-to-memory arbiter. The instruction cache (port 0) and the
// data cache (port 1) share one block-wide memory port. One transaction is
// outstanding at a time. It moves through IDLE -> BUSY -> DONE -> IDLE.
// A busy counter aborts a transaction that memory never acknowledges.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int BLOCK_SIZE = 2,
    parameter int RR_MODE    = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [1:0]                                req_cs,
    input  logic [1:0]                                req_rw,
    input  logic [1:0][ADDR_WIDTH-1:0]                req_addr,
    input  logic [1:0][WORD_WIDTH*BLOCK_SIZE-1:0]     req_wdata,
    output logic [1:0]                                req_ack,
    output logic [1:0]                                req_err,
    output logic [1:0][WORD_WIDTH*BLOCK_SIZE-1:0]     req_rdata,
    output logic                                      mem_cs,
    output logic                                      mem_rw,
    output logic [ADDR_WIDTH-1:0]                     mem_addr,
    output logic [WORD_WIDTH*BLOCK_SIZE-1:0]          mem_wdata,
    input  logic                                      mem_ack,
    input  logic [WORD_WIDTH*BLOCK_SIZE-1:0]          mem_rdata,
    output logic                                      grant
);

    // The busy counter is 8 bits wide. The timeout is compared against the
    // count before it increments, so TIMEOUT BUSY cycles elapse before the
    // transaction is aborted.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] busy_cnt;
    logic       winner;
    logic       timeout_hit;

    // Pick the next owner. A lone request always wins. On a tie, round-robin
    // mode serves the port that was not granted last. Fixed mode favours the
    // data cache.
    always_comb begin
        winner = 1'b0;
        if (req_cs == 2'b11) begin
            winner = (RR_MODE != 0) ? ~last_grant : 1'b1;
        end else begin
            winner = req_cs[1];
        end
    end

    // This cycle is the last BUSY cycle the transaction is allowed. It
    // matters only when mem_ack is low, because a late ack still counts as
    // success.
    assign timeout_hit = (busy_cnt == (TIMEOUT_CNT - 8'd1));

    // Arbiter state machine. All outputs are registered. The ack and err
    // pulses clear by default, so each one lasts exactly one cycle: the DONE
    // cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_cs     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_ack    <= '0;
            req_err    <= '0;
            req_rdata  <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            busy_cnt   <= '0;
        end else begin
            req_ack <= '0;
            req_err <= '0;
            case (state)
                IDLE: begin
                    if (|req_cs) begin
                        grant      <= winner;
                        last_grant <= winner;
                        mem_rw     <= req_rw[winner];
                        mem_addr   <= req_addr[winner];
                        mem_wdata  <= req_wdata[winner];
                        mem_cs     <= 1'b1;
                        busy_cnt   <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    busy_cnt <= busy_cnt + 8'd1;
                    if (mem_ack) begin
                        if (!mem_rw) begin
                            req_rdata[grant] <= mem_rdata;
                        end
                        req_ack[grant] <= 1'b1;
                        mem_cs         <= 1'b0;
                        state          <= DONE;
                    end else if (timeout_hit) begin
                        req_err[grant] <= 1'b1;
                        mem_cs         <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter. Two instances share one set of stimulus:
//   instance 0 (u_rr) uses round-robin arbitration with TIMEOUT=255;
//   instance 1 (u_fp) uses fixed priority with TIMEOUT=4.
// A transaction-level model predicts both instances. A compare process checks
// every output on every falling edge. Directed scenarios add hand-computed
// literal checks on top of the model.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int BS = 2;
    localparam int DW = WW * BS;
    localparam int TO_RR = 255;
    localparam int TO_FP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [1:0]            req_cs;
    logic [1:0]            req_rw;
    logic [1:0][AW-1:0]    req_addr;
    logic [1:0][DW-1:0]    req_wdata;
    logic                  mem_ack;
    logic [DW-1:0]         mem_rdata;

    logic [1:0]            dut_req_ack   [2];
    logic [1:0]            dut_req_err   [2];
    logic [1:0][DW-1:0]    dut_req_rdata [2];
    logic                  dut_mem_cs    [2];
    logic                  dut_mem_rw    [2];
    logic [AW-1:0]         dut_mem_addr  [2];
    logic [DW-1:0]         dut_mem_wdata [2];
    logic                  dut_grant     [2];

    int total_checks = 0;
    int bad_checks   = 0;

    cache_mem_arbiter #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS),
        .RR_MODE(1), .TIMEOUT(TO_RR)
    ) u_rr (
        .clk(clk), .rst(rst),
        .req_cs(req_cs), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(dut_req_ack[0]), .req_err(dut_req_err[0]), .req_rdata(dut_req_rdata[0]),
        .mem_cs(dut_mem_cs[0]), .mem_rw(dut_mem_rw[0]), .mem_addr(dut_mem_addr[0]),
        .mem_wdata(dut_mem_wdata[0]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant(dut_grant[0])
    );

    cache_mem_arbiter #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BLOCK_SIZE(BS),
        .RR_MODE(0), .TIMEOUT(TO_FP)
    ) u_fp (
        .clk(clk), .rst(rst),
        .req_cs(req_cs), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(dut_req_ack[1]), .req_err(dut_req_err[1]), .req_rdata(dut_req_rdata[1]),
        .mem_cs(dut_mem_cs[1]), .mem_rw(dut_mem_rw[1]), .mem_addr(dut_mem_addr[1]),
        .mem_wdata(dut_mem_wdata[1]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant(dut_grant[1])
    );

    // Transaction-level model, one slot per instance.
    // The phase values are: 0 = waiting for a request, 1 = memory access in
    // flight, 2 = completion being reported.
    int          m_phase [2];
    int          m_owner [2];
    int          m_last  [2];
    int          m_busy  [2];
    bit          m_ok    [2];
    logic        m_rw    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2][2];
    bit          m_valid = 1'b0;

    function automatic int timeoutOf(input int i);
        return (i == 0) ? TO_RR : TO_FP;
    endfunction

    function automatic bit roundRobinOf(input int i);
        return (i == 0);
    endfunction

    // Advance one instance's model by one clock, using the inputs sampled at
    // this edge.
    task automatic modelStep(input int i);
        int win;
        if (rst) begin
            m_phase[i] = 0;
            m_owner[i] = 0;
            m_last[i]  = 1;
            m_busy[i]  = 0;
            m_ok[i]    = 1'b0;
            m_rw[i]    = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_rdata[i][0] = '0;
            m_rdata[i][1] = '0;
            m_valid = 1'b1;
        end else if (m_phase[i] == 0) begin
            if (req_cs != 2'b00) begin
                if (req_cs == 2'b11)
                    win = roundRobinOf(i) ? (1 - m_last[i]) : 1;
                else
                    win = req_cs[1] ? 1 : 0;
                m_owner[i] = win;
                m_last[i]  = win;
                m_rw[i]    = req_rw[win];
                m_addr[i]  = req_addr[win];
                m_wdata[i] = req_wdata[win];
                m_busy[i]  = 0;
                m_phase[i] = 1;
            end
        end else if (m_phase[i] == 1) begin
            m_busy[i] = m_busy[i] + 1;
            if (mem_ack) begin
                m_ok[i] = 1'b1;
                if (m_rw[i] == 1'b0) m_rdata[i][m_owner[i]] = mem_rdata;
                m_phase[i] = 2;
            end else if (m_busy[i] == timeoutOf(i)) begin
                m_ok[i] = 1'b0;
                m_phase[i] = 2;
            end
        end else begin
            m_phase[i] = 0;
        end
    endtask

    // Model update on every rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) modelStep(i);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output of one instance against the model's prediction.
    task automatic compareInstance(input int i, input string tag);
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        exp_ack = 2'b00;
        exp_err = 2'b00;
        if (m_phase[i] == 2) begin
            if (m_ok[i]) exp_ack[m_owner[i]] = 1'b1;
            else         exp_err[m_owner[i]] = 1'b1;
        end
        checkOutput({tag, " mem_cs"},    64'(dut_mem_cs[i]),    64'(m_phase[i] == 1));
        checkOutput({tag, " mem_rw"},    64'(dut_mem_rw[i]),    64'(m_rw[i]));
        checkOutput({tag, " mem_addr"},  64'(dut_mem_addr[i]),  64'(m_addr[i]));
        checkOutput({tag, " mem_wdata"}, dut_mem_wdata[i],      m_wdata[i]);
        checkOutput({tag, " req_ack"},   64'(dut_req_ack[i]),   64'(exp_ack));
        checkOutput({tag, " req_err"},   64'(dut_req_err[i]),   64'(exp_err));
        checkOutput({tag, " rdata0"},    dut_req_rdata[i][0],   m_rdata[i][0]);
        checkOutput({tag, " rdata1"},    dut_req_rdata[i][1],   m_rdata[i][1]);
        checkOutput({tag, " grant"},     64'(dut_grant[i]),     64'(m_owner[i]));
    endtask

    // Per-cycle comparison on the falling edge, once the first reset has been
    // seen.
    always @(negedge clk) begin
        if (m_valid) begin
            compareInstance(0, "rr");
            compareInstance(1, "fp");
        end
    end

    task automatic applyStimulus(input logic [1:0] cs, input logic [1:0] rw,
                                 input logic ack, input logic [DW-1:0] rdata);
        req_cs    = cs;
        req_rw    = rw;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] DATA1 = 64'hDEAD0001_BEEF0002;
    localparam logic [DW-1:0] WDAT3 = 64'hCAFE0003_F00D0004;
    localparam logic [DW-1:0] JUNK3 = 64'h5555AAAA_5555AAAA;
    localparam logic [DW-1:0] DATA4 = 64'h12345678_9ABCDEF0;

    initial begin
        logic [31:0] cv;
        rst = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        applyStimulus(2'b00, 2'b00, 1'b0, '0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset mem_cs", 64'(dut_mem_cs[0]), 64'd0);
        checkOutput("reset grant", 64'(dut_grant[0]), 64'd0);
        checkOutput("reset rdata0", dut_req_rdata[0][0], 64'd0);
        tick();

        // Scenario 1: port 0 reads 0x40 and memory acks in the first BUSY cycle.
        rst = 1'b0;
        req_addr[0] = 32'h40;
        applyStimulus(2'b01, 2'b00, 1'b0, '0);
        tick();
        applyStimulus(2'b01, 2'b00, 1'b1, DATA1);
        @(negedge clk);
        checkOutput("s1 mem_cs c1", 64'(dut_mem_cs[0]), 64'd1);
        checkOutput("s1 mem_addr c1", 64'(dut_mem_addr[0]), 64'h40);
        tick();
        applyStimulus(2'b00, 2'b00, 1'b0, '0);
        @(negedge clk);
        checkOutput("s1 ack rr c2", 64'(dut_req_ack[0]), 64'd1);
        checkOutput("s1 rdata0 rr", dut_req_rdata[0][0], DATA1);
        checkOutput("s1 grant rr", 64'(dut_grant[0]), 64'd0);
        checkOutput("s1 ack fp c2", 64'(dut_req_ack[1]), 64'd1);
        tick();

        // Scenario 2: both ports request continuously after reset, with memory
        // always acking.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_addr[0] = 32'h100;
        req_addr[1] = 32'h200;
        for (int c = 0; c < 12; c++) begin
            cv = 32'(c);
            applyStimulus(2'b11, 2'b00, 1'b1, {32'hA0000000 + cv, 32'hB0000000 + cv});
            @(negedge clk);
            if (c % 3 == 2) begin
                checkOutput("s2 rr ack", 64'(dut_req_ack[0]), ((c / 3) % 2 == 0) ? 64'd1 : 64'd2);
                checkOutput("s2 fp ack", 64'(dut_req_ack[1]), 64'd2);
            end
            tick();
        end

        // Scenario 3: port 1 writes 0x80 and memory acks in the fifth BUSY
        // cycle. The fixed-priority instance times out after 4 BUSY cycles.
        req_addr[1]  = 32'h80;
        req_wdata[1] = WDAT3;
        applyStimulus(2'b10, 2'b10, 1'b0, JUNK3);
        tick();
        for (int s = 1; s <= 5; s++) begin
            applyStimulus(2'b10, 2'b10, (s == 5), JUNK3);
            @(negedge clk);
            checkOutput("s3 rr mem_cs", 64'(dut_mem_cs[0]), 64'd1);
            checkOutput("s3 rr mem_addr", 64'(dut_mem_addr[0]), 64'h80);
            checkOutput("s3 rr mem_wdata", dut_mem_wdata[0], WDAT3);
            checkOutput("s3 rr mem_rw", 64'(dut_mem_rw[0]), 64'd1);
            if (s == 5) checkOutput("s3 fp err", 64'(dut_req_err[1]), 64'd2);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 1'b0, JUNK3);
        @(negedge clk);
        checkOutput("s3 rr ack", 64'(dut_req_ack[0]), 64'd2);
        checkOutput("s3 rr rdata1 kept", dut_req_rdata[0][1], 64'hA000000A_B000000A);
        checkOutput("s3 fp ack", 64'(dut_req_ack[1]), 64'd0);
        tick();

        // Scenario 4: port 0 reads 0x44 and memory never acks. The requester
        // drops req_cs while BUSY. The fixed-priority instance times out; the
        // round-robin instance is then reset mid-transaction.
        req_addr[0] = 32'h44;
        applyStimulus(2'b01, 2'b00, 1'b0, '0);
        tick();
        for (int t = 1; t <= 5; t++) begin
            applyStimulus((t < 2) ? 2'b01 : 2'b00, 2'b00, 1'b0, '0);
            @(negedge clk);
            checkOutput("s4 fp ack", 64'(dut_req_ack[1]), 64'd0);
            if (t == 5) checkOutput("s4 fp err", 64'(dut_req_err[1]), 64'd1);
            tick();
        end
        @(negedge clk);
        checkOutput("s4 fp idle mem_cs", 64'(dut_mem_cs[1]), 64'd0);
        checkOutput("s4 rr busy mem_cs", 64'(dut_mem_cs[0]), 64'd1);
        checkOutput("s4 rr mem_addr", 64'(dut_mem_addr[0]), 64'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_addr[1] = 32'h88;
        applyStimulus(2'b10, 2'b00, 1'b0, '0);
        @(negedge clk);
        checkOutput("s4 rst mem_cs", 64'(dut_mem_cs[0]), 64'd0);
        checkOutput("s4 rst mem_addr", 64'(dut_mem_addr[0]), 64'd0);
        checkOutput("s4 rst grant", 64'(dut_grant[0]), 64'd0);
        checkOutput("s4 rst rdata0", dut_req_rdata[0][0], 64'd0);
        checkOutput("s4 rst rdata1", dut_req_rdata[0][1], 64'd0);
        checkOutput("s4 rst ack", 64'(dut_req_ack[0]), 64'd0);
        tick();
        applyStimulus(2'b10, 2'b00, 1'b1, DATA4);
        @(negedge clk);
        checkOutput("s4 new mem_cs", 64'(dut_mem_cs[0]), 64'd1);
        checkOutput("s4 new mem_addr", 64'(dut_mem_addr[0]), 64'h88);
        tick();
        applyStimulus(2'b00, 2'b00, 1'b0, '0);
        @(negedge clk);
        checkOutput("s4 new ack rr", 64'(dut_req_ack[0]), 64'd2);
        checkOutput("s4 new rdata1 rr", dut_req_rdata[0][1], DATA4);
        checkOutput("s4 new grant rr", 64'(dut_grant[0]), 64'd1);
        checkOutput("s4 new ack fp", 64'(dut_req_ack[1]), 64'd2);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the block address width, equal to the memory_mapping value.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, meaning the data word width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 2, meaning words per cache block moved per transaction.
REQ-004 The block SHALL have parameter RR_MODE, default 1, meaning 1 selects round-robin arbitration and 0 selects fixed priority with port 1 winning.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles before abort, 1..255.
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have the ports req_cs[n], req_rw[n] and req_addr[n], inputs of 1, 1 and ADDR_WIDTH bits, for n=0 (instruction cache) and n=1 (data cache): chip select, read 0/write 1, and block address.
REQ-009 The block SHALL have the port req_wdata[n], input, WORD_WIDTH*BLOCK_SIZE bits: the write block, with word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-010 The block SHALL have the ports req_ack[n] (1 bit) and req_rdata[n] (WORD_WIDTH*BLOCK_SIZE bits), outputs: one-cycle completion pulse and the read block.
REQ-011 The block SHALL have the ports req_err[n], output, 1 bit: one-cycle pulse marking a timed-out transaction.
REQ-012 The block SHALL have the ports mem_cs, mem_rw, mem_addr and mem_wdata, outputs of 1, 1, ADDR_WIDTH and WORD_WIDTH*BLOCK_SIZE bits: the memory request.
REQ-013 The block SHALL have the ports mem_ack (1 bit) and mem_rdata (WORD_WIDTH*BLOCK_SIZE bits), inputs: the memory response.
REQ-014 The block SHALL have the port grant, output, 1 bit: index of the port owning the current or most recent transaction.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-016 In IDLE with any req_cs high, the block SHALL select a winner, latch its rw, addr and wdata, set grant, and enter BUSY the next cycle.
REQ-017 Arbitration SHALL be: if only one req_cs is high, that port wins; if both are high, RR_MODE=1 picks the port not granted last and RR_MODE=0 picks port 1.
REQ-018 In BUSY, mem_cs SHALL be a registered 1 and mem_rw/mem_addr/mem_wdata SHALL hold the latched values, stable until BUSY exits.
REQ-019 mem_ack sampled high in BUSY SHALL register mem_rdata into req_rdata[grant], enter DONE, and drive mem_cs to 0 in DONE.
REQ-020 In DONE, req_ack[grant] SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE the following cycle and ignore req_cs during DONE.
REQ-021 Minimum latency SHALL be: req_cs sampled in cycle 0, mem_cs high in cycle 1, mem_ack in cycle 1, req_ack in cycle 2.
REQ-022 req_rdata[n] SHALL hold its value until the next read completion on port n; writes SHALL NOT update req_rdata.
REQ-023 A requester SHALL keep req_cs high until req_ack; dropping req_cs during BUSY SHALL NOT abort the transaction, and ack still pulses.
REQ-024 mem_ack while not in BUSY SHALL be ignored.
REQ-025 An 8-bit busy counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-026 If the busy counter reaches TIMEOUT without mem_ack, the block SHALL enter DONE with req_err[grant] pulsed instead of req_ack and req_rdata unchanged.
REQ-027 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as success.
REQ-028 The non-granted port SHALL never see req_ack or req_err.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, mem_cs=0, mem_rw=0, mem_addr=0, mem_wdata=0, all req_ack/req_err=0, req_rdata=0, grant=0, last-grant=1 and busy counter=0.
REQ-030 rst asserted during BUSY SHALL abort the transaction, with mem_cs low the cycle after the reset edge and no ack pulsed.

Verification
REQ-031 The bench SHALL cover: port 0 read of addr 0x40, mem_ack on the first BUSY cycle with data {0xDEAD0001,0xBEEF0002} -> req_ack[0] at cycle 2, req_rdata[0] equal to that data, grant=0.
REQ-032 The bench SHALL cover: both ports requesting in the same cycle after reset with RR_MODE=1 -> port 0 served first, then port 1 served with one DONE cycle between.
REQ-033 The bench SHALL cover: RR_MODE=0 with both ports requesting repeatedly -> port 1 wins every tie.
REQ-034 The bench SHALL cover: port 1 write of addr 0x80 with mem_ack delayed 5 cycles -> mem_cs high for 5 cycles with stable address/data, then req_ack[1], req_rdata[1] unchanged.
REQ-035 The bench SHALL cover: TIMEOUT=4 with mem_ack never asserted -> req_err[grant] pulses after 4 BUSY cycles, no req_ack, FSM back to IDLE.
REQ-036 The bench SHALL cover: rst during BUSY -> mem_cs=0 next cycle, all outputs at reset values, and a new request is served normally afterward.
